aes_sub_bytes_iter: RTL

- Iterative SubBytes/InvSubBytes engine for the 128-bit AES state in the round datapath.
- Accepts one state word, substitutes BYTES_PER_CYCLE bytes per clock, then presents the result.
- Forward direction instantiates the team's forward aes_sbox. Inverse direction instantiates inv_aes_sbox.
- Lets the encrypt and decrypt round logic share one area-scaled substitution unit.

---
 rtl/aes_sub_bytes_iter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/aes_sub_bytes_iter.sv
// Iterative SubBytes/InvSubBytes over a 128-bit AES state. BYTES_PER_CYCLE
// S-box lanes per direction are reused across NUM_STEPS cycles.

package aes_gf_pkg;
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8); it also maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = a;
    for (int i = 1; i < 8; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction
endpackage

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  import aes_gf_pkg::*;
  logic [7:0] t;
  assign t = gf_inv(a);
  assign y = t ^ rotl8(t, 1) ^ rotl8(t, 2) ^ rotl8(t, 3) ^ rotl8(t, 4) ^ 8'h63;
endmodule

module inv_aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  import aes_gf_pkg::*;
  logic [7:0] t;
  assign t = rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05;
  assign y = gf_inv(t);
endmodule

module aes_sub_bytes_iter #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);
  localparam int NUM_STEPS = 16 / BYTES_PER_CYCLE;
  localparam int CNT_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NUM_STEPS - 1);

  if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
        BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bpc_check
    $error("BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [127:0]                 data_q, data_d;
  logic                         mode_q, mode_d;
  logic                         accept;
  logic [8*BYTES_PER_CYCLE-1:0] lane_res;

  assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = data_q;

  // Lane l works on byte cnt*BPC+l of the held state; both directions are
  // evaluated and the latched mode picks one.
  for (genvar l = 0; l < BYTES_PER_CYCLE; l++) begin : g_lane
    logic [7:0] lin, lfwd, linv;
    assign lin = data_q[127 - 8*(int'(cnt_q)*BYTES_PER_CYCLE + l) -: 8];
    aes_sbox     u_fwd (.a(lin), .y(lfwd));
    inv_aes_sbox u_inv (.a(lin), .y(linv));
    assign lane_res[8*l +: 8] = mode_q ? linv : lfwd;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: ;
      BUSY: begin
        for (int l = 0; l < BYTES_PER_CYCLE; l++)
          data_d[127 - 8*(int'(cnt_q)*BYTES_PER_CYCLE + l) -: 8] = lane_res[8*l +: 8];
        if (cnt_q == LAST_STEP) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Acceptance in DONE overrides the return to IDLE, so there is no bubble.
    if (accept) begin
      state_d = BUSY;
      cnt_d   = '0;
      data_d  = in_data;
      mode_d  = in_inv;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
    end
  end
endmodule
